instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage of the MIPS-DLX pipeline, directly upstream of instruction decode. Owns the program counter, drives a req/ack instruction-memory port, and loads the IF/ID pipeline register. Consumes the decode stage's branch-resolution output `PC_sel` and branch target to redirect fetch, and the hazard unit's `stall` to freeze.

## Interface
- `ADDR_W`, 32: PC and instruction-address width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word aligned.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC_sel`  in  1  taken-branch redirect request from decode.
- `branch_target`  in  ADDR_W  redirect address; bits [1:0] ignored and forced to 00.
- `stall`  in  1  hazard freeze; holds PC and IF/ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address, equal to the PC register.
- `imem_ack`  in  1  instruction valid on `imem_rdata` this cycle.
- `imem_rdata`  in  DATA_W  fetched instruction.
- `IF_ID_instr`  out  DATA_W  registered instruction to decode.
- `IF_ID_pc4`  out  ADDR_W  registered PC+4 of that instruction.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: entered on reset. `imem_req`=0. Moves to FETCH on the next edge unconditionally.
  - FETCH: `imem_req`=1.
  - HOLD: `imem_req`=0. A fetched instruction is parked in the hold buffer with its PC+4.
- While `imem_req`=1 and no ack, `imem_addr` stays stable.
- FETCH with ack and stall=0:
  - Load IF/ID with `imem_rdata`, pc+4, valid=1.
  - pc <= pc+4.
- FETCH with ack and stall=1:
  - Capture the instruction into the hold buffer.
  - pc <= pc+4; go to HOLD.
  - IF/ID unchanged.
- FETCH, no ack, stall=0: IF_ID_valid <= 0 (bubble); `IF_ID_instr` and `IF_ID_pc4` keep their values.
- FETCH, no ack, stall=1: IF/ID unchanged.
- HOLD with stall=0: IF/ID <= buffer (valid=1); go to FETCH.
- Redirect:
  - Taken only when PC_sel=1 and stall=0. stall=1 masks PC_sel.
  - With ack in the same cycle: discard `imem_rdata`, pc <= target, IF_ID_valid <= 0, stay in FETCH.
  - Without ack: latch target into `redir_pc`, set `discard`, IF_ID_valid <= 0.
  - On the later ack: drop the data, pc <= `redir_pc`, clear `discard`.
  - In the HOLD->FETCH cycle: the buffered instruction is dropped (valid=0) and pc <= target.
- PC_sel is ignored while `discard` is set.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W. pc[1:0] is always 00.

## Timing
- Reset values:
  - pc = RESET_PC; `imem_addr` = RESET_PC; `imem_req` = 0.
  - `IF_ID_instr` = 0 (NOP); `IF_ID_pc4` = 0; `IF_ID_valid` = 0.
  - Hold buffer = 0; `discard` = 0; `redir_pc` = 0; state = IDLE.
- Reset asserted mid-request abandons the request immediately. Any ack arriving after reset is ignored.
- First `imem_req` is in the first cycle after reset release.
- With zero-wait memory (ack in the request cycle), throughput is one instruction per cycle. Fetch-to-IF/ID latency is one edge.
- Redirect penalty without delay slot: one bubble with zero-wait memory.
- `imem_req` is a Moore output of the state. `imem_addr` is driven from the pc register.

## Configuration
- `IF_DELAY_SLOT_EN`
  - Defined: the fetch in flight when a redirect is taken is the delay slot and is kept.
    - With ack: IF/ID <= instr, valid=1, pc <= target.
    - Without ack: IF_ID_valid <= 0 and a pending redirect is recorded. On the later ack, IF/ID is loaded normally and pc <= `redir_pc`.
    - HOLD->FETCH redirect: the buffered instruction is delivered (valid=1).
  - Undefined: flush behaviour as in Operation; no delay slot.

## Test plan
- Reset, then ack every cycle with rdata = 0x1000_0000+addr -> first req at addr 0x0. IF/ID shows pc4 0x4, 0x8, 0xC on consecutive edges, valid=1.
- Ack withheld 3 cycles at addr 0x8 -> `imem_addr` holds 0x8, three bubbles (valid=0), then instruction at 0x8 with pc4=0xC.
- stall=1 for 2 cycles while ack arrives at 0x10 -> state HOLD, `imem_req`=0, IF/ID frozen. On release, IF/ID = instr@0x10, next req at 0x14.
- PC_sel=1 with target 0x40 while fetching 0x14 with ack:
  - Macro undefined: bubble, next req 0x40.
  - Macro defined: instr@0x14 valid, next req 0x40.
- PC_sel=1, target 0x80, ack delayed 2 cycles -> addr stays 0x14, data dropped on ack, next req 0x80. PC_sel=1 with stall=1 -> no redirect.
- `rst_n` low mid-request with ack pending -> outputs return to reset values at once. Restart fetches from RESET_PC; the late ack is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory request/acknowledge bus between the fetch stage and the
// instruction memory.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_ack   : instruction valid on imem_rdata this cycle (memory -> fetch)
//   imem_rdata : fetched instruction (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage of the DLX pipeline. Owns the program counter, issues
// requests on a req/ack instruction-memory bus and loads the IF/ID register.
// Decode redirects fetch through PC_sel/branch_target; the hazard unit freezes
// PC and IF/ID through stall. A fetch acknowledged during a stall is parked in
// a hold buffer (HOLD state) until the stall lifts.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   PC_sel         : taken-branch redirect request from decode
//   branch_target  : redirect address (bits [1:0] forced to 00)
//   stall          : hazard freeze of PC and IF/ID
//   imem           : instr_fetch_if.master (imem_req/addr/ack/rdata)
//   IF_ID_instr    : registered instruction to decode
//   IF_ID_pc4      : registered PC+4 of that instruction
//   IF_ID_valid    : IF/ID holds a real instruction (0 = bubble)
//
// Build option: define IF_DELAY_SLOT_EN to keep the fetch in flight when a
// redirect is taken (branch delay slot). Undefined: that fetch is flushed.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  instr_fetch_if.master     imem,
  output logic [DATA_W-1:0] IF_ID_instr,
  output logic [ADDR_W-1:0] IF_ID_pc4,
  output logic              IF_ID_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

  state_t            state_r;
  logic              req_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] hold_instr_r;
  logic [ADDR_W-1:0] hold_pc4_r;
  logic              discard_r;
  logic [ADDR_W-1:0] redir_pc_r;
  logic [DATA_W-1:0] if_id_instr_r;
  logic [ADDR_W-1:0] if_id_pc4_r;
  logic              if_id_valid_r;

  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] target_s;
  logic              redirect_s;

  // pc+4 wraps naturally at ADDR_W bits; stall masks a redirect, and a redirect
  // already waiting for its ack suppresses any newer one.
  assign pc4_s      = pc_r + PC_STEP;
  assign target_s   = branch_target & ALIGN_MASK;
  assign redirect_s = PC_sel & ~stall & ~discard_r;

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign IF_ID_instr    = if_id_instr_r;
  assign IF_ID_pc4      = if_id_pc4_r;
  assign IF_ID_valid    = if_id_valid_r;

  // Fetch FSM: PC, request, hold buffer, pending redirect and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      req_r         <= 1'b0;
      pc_r          <= RESET_PC;
      hold_instr_r  <= {DATA_W{1'b0}};
      hold_pc4_r    <= {ADDR_W{1'b0}};
      discard_r     <= 1'b0;
      redir_pc_r    <= {ADDR_W{1'b0}};
      if_id_instr_r <= {DATA_W{1'b0}};
      if_id_pc4_r   <= {ADDR_W{1'b0}};
      if_id_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Acks seen here belong to a request abandoned by reset.
          state_r <= FETCH;
          req_r   <= 1'b1;
        end

        FETCH: begin
          if (imem.imem_ack) begin
            if (discard_r) begin
              // Ack of the fetch that was in flight when the redirect was taken.
              discard_r <= 1'b0;
              pc_r      <= redir_pc_r;
`ifdef IF_DELAY_SLOT_EN
              if (stall) begin
                hold_instr_r <= imem.imem_rdata;
                hold_pc4_r   <= pc4_s;
                state_r      <= HOLD;
                req_r        <= 1'b0;
              end else begin
                if_id_instr_r <= imem.imem_rdata;
                if_id_pc4_r   <= pc4_s;
                if_id_valid_r <= 1'b1;
              end
`else
              if (!stall) begin
                if_id_valid_r <= 1'b0;
              end
`endif
            end else if (stall) begin
              // Park the instruction; PC already advances past it.
              hold_instr_r <= imem.imem_rdata;
              hold_pc4_r   <= pc4_s;
              pc_r         <= pc4_s;
              state_r      <= HOLD;
              req_r        <= 1'b0;
            end else if (redirect_s) begin
              pc_r <= target_s;
`ifdef IF_DELAY_SLOT_EN
              if_id_instr_r <= imem.imem_rdata;
              if_id_pc4_r   <= pc4_s;
              if_id_valid_r <= 1'b1;
`else
              if_id_valid_r <= 1'b0;
`endif
            end else begin
              if_id_instr_r <= imem.imem_rdata;
              if_id_pc4_r   <= pc4_s;
              if_id_valid_r <= 1'b1;
              pc_r          <= pc4_s;
            end
          end else if (!stall) begin
            // No ack: bubble; imem_addr must stay put, so a redirect is parked.
            if_id_valid_r <= 1'b0;
            if (redirect_s) begin
              redir_pc_r <= target_s;
              discard_r  <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (!stall) begin
            state_r <= FETCH;
            req_r   <= 1'b1;
            if (redirect_s) begin
              pc_r <= target_s;
`ifdef IF_DELAY_SLOT_EN
              if_id_instr_r <= hold_instr_r;
              if_id_pc4_r   <= hold_pc4_r;
              if_id_valid_r <= 1'b1;
`else
              if_id_valid_r <= 1'b0;
`endif
            end else begin
              if_id_instr_r <= hold_instr_r;
              if_id_pc4_r   <= hold_pc4_r;
              if_id_valid_r <= 1'b1;
            end
          end
        end

        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
